// File: rtl/sync_debounce_if.sv
// Bundle of the debounce stage's per-channel inputs and qualified outputs.
// dbg_pending exposes each channel's STABLE/PENDING state for checkers.
interface sync_debounce_if #(
  parameter int CHANNELS = 4
);
  logic                tick_en;
  logic [CHANNELS-1:0] sig_in;
  logic [CHANNELS-1:0] event_ack;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] event_flag;
  logic                event_any;
  logic [CHANNELS-1:0] dbg_pending;

  // Producer/consumer side: drives raw inputs and acks, observes results.
  modport master (
    output tick_en, sig_in, event_ack,
    input  level, rise, fall, event_flag, event_any, dbg_pending
  );

  // Debounce stage side.
  modport slave (
    input  tick_en, sig_in, event_ack,
    output level, rise, fall, event_flag, event_any, dbg_pending
  );
endinterface

// File: rtl/sync_debounce.sv
// Multi-channel debounce: a channel adopts a new level after DEBOUNCE_TICKS
// consecutive qualifying ticks, emitting rise/fall pulses and sticky event flags.
module sync_debounce #(
  parameter int                       CHANNELS       = 4,
  parameter int                       COUNT_WIDTH    = 16,
  parameter int                       DEBOUNCE_TICKS = 50000,
  parameter logic [CHANNELS-1:0]      INIT_LEVEL     = '0
) (
  input  logic           clock,
  input  logic           reset_n,
  sync_debounce_if.slave bus
);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } ch_state_e;

  localparam logic [COUNT_WIDTH-1:0] LAST_CNT = COUNT_WIDTH'(DEBOUNCE_TICKS - 1);

  logic [COUNT_WIDTH-1:0] cnt_q   [CHANNELS];
  logic [COUNT_WIDTH-1:0] cnt_d   [CHANNELS];
  ch_state_e              state_q [CHANNELS];
  ch_state_e              state_d [CHANNELS];
  logic [CHANNELS-1:0]    level_q, level_d;
  logic [CHANNELS-1:0]    rise_q,  rise_d;
  logic [CHANNELS-1:0]    fall_q,  fall_d;
  logic [CHANNELS-1:0]    flag_q,  flag_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]   <= '0;
        state_q[i] <= ST_STABLE;
      end
      level_q <= INIT_LEVEL;
      rise_q  <= '0;
      fall_q  <= '0;
      flag_q  <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]   <= cnt_d[i];
        state_q[i] <= state_d[i];
      end
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    flag_d  = flag_q;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]   = cnt_q[i];
      state_d[i] = state_q[i];
      if (bus.sig_in[i] == level_q[i]) begin
        // Any return to the current level throws away accumulated progress.
        cnt_d[i] = '0;
      end else if (bus.tick_en) begin
        if (cnt_q[i] == LAST_CNT) begin
          level_d[i] = bus.sig_in[i];
          rise_d[i]  = bus.sig_in[i];
          fall_d[i]  = ~bus.sig_in[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
        end
      end
      state_d[i] = (cnt_d[i] != '0) ? ST_PENDING : ST_STABLE;

      // A new accepted edge outranks a same-cycle ack so no event is lost.
      if (rise_d[i] || fall_d[i]) begin
        flag_d[i] = 1'b1;
      end else if (bus.event_ack[i]) begin
        flag_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    bus.dbg_pending = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.dbg_pending[i] = (state_q[i] == ST_PENDING);
    end
  end

  assign bus.level      = level_q;
  assign bus.rise       = rise_q;
  assign bus.fall       = fall_q;
  assign bus.event_flag = flag_q;
  assign bus.event_any  = |flag_q;

endmodule

// File: doc/sync_debounce.md
Name:
sync_debounce

Overview:
- Multi-channel debounce and edge-event stage that sits directly downstream of the 2-flop `sync` synchronizer.
- Consumes already-synchronized slow inputs (PTT, key dot/dash, IO lines) and qualifies each one as stable for a programmable number of ticks.
- Produces clean levels, one-cycle rise/fall pulses, and sticky event flags with a per-channel acknowledge, for protocol/control logic.

Parameters:
- CHANNELS, 4: number of independent input channels (≥1).
- COUNT_WIDTH, 16: width of each per-channel stability counter.
- DEBOUNCE_TICKS, 50000: consecutive qualifying ticks required to accept a new level (1 ≤ value < 2^COUNT_WIDTH).
- INIT_LEVEL, {CHANNELS{1'b0}}: per-channel value of `level` after reset.

Ports:
- clock  input  1  single clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- tick_en  input  1  prescale strobe; stability counters advance only on edges where this is 1.
- sig_in  input  CHANNELS  synchronized raw inputs, one per channel, each from a `sync` instance.
- event_ack  input  CHANNELS  per-channel clear strobe for `event_flag`.
- level  output  CHANNELS  debounced level (registered).
- rise  output  CHANNELS  one-cycle pulse when `level` goes 0→1 (registered).
- fall  output  CHANNELS  one-cycle pulse when `level` goes 1→0 (registered).
- event_flag  output  CHANNELS  sticky flag, set on any accepted edge (registered).
- event_any  output  1  OR-reduction of `event_flag` (combinational from registers).

Behaviour:
- Reset (reset_n=0, at any time including mid-count):
  - level=INIT_LEVEL; all counters=0; rise=fall=0; event_flag=0.
  - Takes effect immediately and asynchronously.
  - First evaluation happens on the first posedge after reset_n rises.
- Per channel i, on each posedge, two states: STABLE (cnt=0) and PENDING (cnt>0):
  - sig_in[i]==level[i]: cnt←0 (regardless of tick_en). Glitch rejection: any return to the current level discards progress.
  - sig_in[i]!=level[i], tick_en=0: cnt holds.
  - sig_in[i]!=level[i], tick_en=1, cnt<DEBOUNCE_TICKS-1: cnt←cnt+1.
  - sig_in[i]!=level[i], tick_en=1, cnt==DEBOUNCE_TICKS-1: level[i]←sig_in[i]; cnt←0; rise[i] or fall[i]←1 for exactly this one cycle.
- The new level is accepted on the DEBOUNCE_TICKS-th consecutive qualifying edge.
  - With tick_en tied 1: input change first sampled at edge k gives level/pulse visible after edge k+DEBOUNCE_TICKS-1.
  - DEBOUNCE_TICKS=1: one-edge latency.
- rise/fall are 0 on every cycle without an accepted transition. rise[i] and fall[i] are never both 1.
- Counters saturate by construction and never wrap.
- event_flag[i] priority, per edge:
  - accepted edge (rise|fall) this cycle → 1;
  - else event_ack[i]=1 → 0;
  - else hold.
  - Set wins over a simultaneous ack, so no event is lost.
  - Ack on an already-clear flag is harmless.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own pulses in the same cycle.

Test Plan:
- DEBOUNCE_TICKS=4, tick_en=1, INIT_LEVEL=0. Apply reset_n low, then high; hold sig_in=0 for 10 cycles → level=0, rise=fall=0, event_flag=0, event_any=0 throughout.
- Same config. sig_in[0] 0→1 sampled at edge k and held → level[0]=1 and rise[0]=1 after edge k+3, rise[0]=0 after k+4, event_flag[0]=1 and event_any=1. Then pulse event_ack[0] for one cycle → event_flag[0]=0, event_any=0.
- Same config. sig_in[1] high for 3 edges then low → level[1] stays 0, no pulse, counter back to 0. A following 4-edge high produces rise[1].
- DEBOUNCE_TICKS=4, tick_en=1 every 3rd cycle. sig_in[2] held high → rise[2] on the 4th tick_en edge after the change (about 10–12 clocks), not before. Counter holds between ticks.
- With level[3]=1 and event_flag[3]=0: drive sig_in[3]=0 so fall[3] occurs on edge m, and assert event_ack[3] on that same edge m → event_flag[3]=1 (set wins). Ack on edge m+1 → 0.
- sig_in[0] pending at cnt=2, then assert reset_n low asynchronously mid-cycle → outputs return to reset values immediately. After release, the channel needs a full 4 fresh qualifying edges before it transitions.
